// File: rtl/imem_port_arbiter_pkg.sv
// Shared encodings, word-index slice macro and defaults for the instruction-memory port arbiter.
`ifndef IMEM_PORT_ARBITER_PKG_SV
`define IMEM_PORT_ARBITER_PKG_SV

`define IMEM_WORD_IDX(addr, abits, wbits) addr[(abits)-1:(wbits)]

package imem_port_arbiter_pkg;

    localparam int unsigned DEFAULT_STARVE_MAX = 8;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_FE   = 2'd1,
        OWNER_LD   = 2'd2
    } owner_e;

    // Width needed to hold the values 0..max inclusive.
    function automatic int unsigned starve_cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

`endif

// File: rtl/imem_arb_starve_cnt.sv
// Saturating count of consecutive cycles the loader was refused; sat_out forces a loader win.
module imem_arb_starve_cnt
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX = DEFAULT_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat_out
);

    localparam int unsigned W = starve_cnt_width(MAX);

    logic [W-1:0] cnt_q;

    // Clear wins over increment so a granted cycle always restarts the count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !sat_out) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign sat_out = (cnt_q == W'(MAX));

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port imem between fetch and loader, routing 1-cycle read responses back.
// Optional performance counters are built when IMEM_ARB_PERF_EN is defined.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int unsigned DBITS        = 32,
    parameter int unsigned IMEMADDRBITS = 16,
    parameter int unsigned IMEMWORDBITS = 2,
    parameter int unsigned STARVE_MAX   = DEFAULT_STARVE_MAX
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 fe_req,
    input  logic [DBITS-1:0]                     fe_addr,
    input  logic                                 fe_kill,
    output logic                                 fe_gnt,
    output logic                                 fe_rvalid,
    output logic [DBITS-1:0]                     fe_rdata,
    input  logic                                 ld_req,
    input  logic                                 ld_we,
    input  logic [DBITS-1:0]                     ld_addr,
    input  logic [DBITS-1:0]                     ld_wdata,
    input  logic                                 ld_lock,
    output logic                                 ld_gnt,
    output logic                                 ld_rvalid,
    output logic [DBITS-1:0]                     ld_rdata,
    output logic                                 mem_en,
    output logic                                 mem_we,
    output logic [IMEMADDRBITS-IMEMWORDBITS-1:0] mem_addr,
    output logic [DBITS-1:0]                     mem_wdata,
    input  logic [DBITS-1:0]                     mem_rdata,
    output logic [31:0]                          perf_fe_stall,
    output logic [31:0]                          perf_ld_grants
);

    arb_state_e       state_q;
    arb_state_e       state_d;
    owner_e           owner_q;
    owner_e           owner_d;
    logic             starve_sat;
    logic [DBITS-1:0] fe_rdata_q;
    logic [DBITS-1:0] ld_rdata_q;
    logic             unused_addr_bits;

    imem_arb_starve_cnt #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (ld_req && !ld_gnt),
        .clr     (ld_gnt || !ld_req),
        .sat_out (starve_sat)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants are withheld while reset is low so the memory is never touched during reset.
    always_comb begin
        fe_gnt  = 1'b0;
        ld_gnt  = 1'b0;
        state_d = state_q;
        if (reset) begin
            case (state_q)
                ARB: begin
                    if (starve_sat && ld_req) begin
                        ld_gnt = 1'b1;
                    end else if (fe_req) begin
                        fe_gnt = 1'b1;
                    end else if (ld_req) begin
                        ld_gnt = 1'b1;
                    end
                    if (ld_gnt && ld_lock) begin
                        state_d = LOCK;
                    end
                end
                LOCK: begin
                    ld_gnt = ld_req;
                    if (!ld_lock) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    assign mem_en    = fe_gnt || ld_gnt;
    assign mem_we    = ld_gnt && ld_we;
    assign mem_wdata = ld_wdata;
    assign mem_addr  = ld_gnt ? `IMEM_WORD_IDX(ld_addr, IMEMADDRBITS, IMEMWORDBITS)
                              : `IMEM_WORD_IDX(fe_addr, IMEMADDRBITS, IMEMWORDBITS);

    assign unused_addr_bits = ^{fe_addr[DBITS-1:IMEMADDRBITS], fe_addr[IMEMWORDBITS-1:0],
                                ld_addr[DBITS-1:IMEMADDRBITS], ld_addr[IMEMWORDBITS-1:0]};

    // A fetch killed in its grant cycle is recorded as no owner, which suppresses its response.
    always_comb begin
        owner_d = OWNER_NONE;
        if (fe_gnt && !fe_kill) begin
            owner_d = OWNER_FE;
        end else if (ld_gnt && !ld_we) begin
            owner_d = OWNER_LD;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign fe_rvalid = reset && (owner_q == OWNER_FE) && !fe_kill;
    assign ld_rvalid = reset && (owner_q == OWNER_LD);

    always_ff @(posedge clk) begin
        if (!reset) begin
            fe_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (fe_rvalid) begin
                fe_rdata_q <= mem_rdata;
            end
            if (ld_rvalid) begin
                ld_rdata_q <= mem_rdata;
            end
        end
    end

    assign fe_rdata = fe_rvalid ? mem_rdata : fe_rdata_q;
    assign ld_rdata = ld_rvalid ? mem_rdata : ld_rdata_q;

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] fe_stall_q;
    logic [31:0] ld_grants_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fe_stall_q  <= '0;
            ld_grants_q <= '0;
        end else begin
            if (fe_req && !fe_gnt) begin
                fe_stall_q <= fe_stall_q + 32'd1;
            end
            if (ld_gnt) begin
                ld_grants_q <= ld_grants_q + 32'd1;
            end
        end
    end

    assign perf_fe_stall  = fe_stall_q;
    assign perf_ld_grants = ld_grants_q;
`else
    assign perf_fe_stall  = '0;
    assign perf_ld_grants = '0;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed scoreboard bench for imem_port_arbiter; perf expectations follow IMEM_ARB_PERF_EN.
module tb_imem_port_arbiter;

    typedef struct {
        int          due;
        logic        is_fe;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fe_req;
    logic [31:0] fe_addr;
    logic        fe_kill;
    logic        fe_gnt;
    logic        fe_rvalid;
    logic [31:0] fe_rdata;
    logic        ld_req;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_lock;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] perf_fe_stall;
    logic [31:0] perf_ld_grants;

    logic [31:0] mem_model [0:255];
    logic [31:0] exp_mem   [0:255];
    resp_t       sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_fe_rdata = '0;
    logic [31:0] exp_ld_rdata = '0;
    int          exp_stall = 0;
    int          exp_ldg = 0;

    imem_port_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .fe_req         (fe_req),
        .fe_addr        (fe_addr),
        .fe_kill        (fe_kill),
        .fe_gnt         (fe_gnt),
        .fe_rvalid      (fe_rvalid),
        .fe_rdata       (fe_rdata),
        .ld_req         (ld_req),
        .ld_we          (ld_we),
        .ld_addr        (ld_addr),
        .ld_wdata       (ld_wdata),
        .ld_lock        (ld_lock),
        .ld_gnt         (ld_gnt),
        .ld_rvalid      (ld_rvalid),
        .ld_rdata       (ld_rdata),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .perf_fe_stall  (perf_fe_stall),
        .perf_ld_grants (perf_ld_grants)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pattern(input int i);
        return 32'(32'h11 * (i + 1));
    endfunction

    // Word memory behind the arbiter; reloads its pattern whenever reset is held low.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) begin
                mem_model[i] <= pattern(i);
            end
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we) begin
                mem_model[mem_addr[7:0]] <= mem_wdata;
            end else begin
                mem_rdata <= mem_model[mem_addr[7:0]];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkPerf();
`ifdef IMEM_ARB_PERF_EN
        checkOutput("perf_fe_stall", perf_fe_stall, 32'(exp_stall));
        checkOutput("perf_ld_grants", perf_ld_grants, 32'(exp_ldg));
`else
        checkOutput("perf_fe_stall", perf_fe_stall, 32'd0);
        checkOutput("perf_ld_grants", perf_ld_grants, 32'd0);
`endif
    endtask

    // One cycle: drive, check at the falling edge against the scoreboard, update the model.
    task automatic applyStimulus(input logic rst, input logic fr, input logic [31:0] fa, input logic kill,
                                 input logic lr, input logic we, input logic [31:0] la,
                                 input logic [31:0] wd, input logic lock,
                                 input logic efg, input logic elg);
        resp_t       r;
        logic        efv;
        logic        elv;
        logic [31:0] addr_exp;
        reset    = rst;
        fe_req   = fr;
        fe_addr  = fa;
        fe_kill  = kill;
        ld_req   = lr;
        ld_we    = we;
        ld_addr  = la;
        ld_wdata = wd;
        ld_lock  = lock;
        @(negedge clk);
        efv = 1'b0;
        elv = 1'b0;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            if (rst) begin
                if (r.is_fe) begin
                    if (!kill) begin
                        efv = 1'b1;
                        exp_fe_rdata = r.data;
                    end
                end else begin
                    elv = 1'b1;
                    exp_ld_rdata = r.data;
                end
            end
        end
        if (!rst) sb.delete();
        checkOutput("fe_gnt", 32'(fe_gnt), 32'(efg));
        checkOutput("ld_gnt", 32'(ld_gnt), 32'(elg));
        checkOutput("mem_en", 32'(mem_en), 32'(efg | elg));
        checkOutput("mem_we", 32'(mem_we), 32'(elg & we));
        if (efg || elg) begin
            addr_exp = elg ? la : fa;
            checkOutput("mem_addr", 32'(mem_addr), {18'd0, addr_exp[15:2]});
        end
        checkOutput("fe_rvalid", 32'(fe_rvalid), 32'(efv));
        checkOutput("ld_rvalid", 32'(ld_rvalid), 32'(elv));
        if (rst) begin
            checkOutput("fe_rdata", fe_rdata, exp_fe_rdata);
            checkOutput("ld_rdata", ld_rdata, exp_ld_rdata);
        end
        if (!rst) begin
            for (int i = 0; i < 256; i++) exp_mem[i] = pattern(i);
            exp_fe_rdata = '0;
            exp_ld_rdata = '0;
            exp_stall = 0;
            exp_ldg = 0;
        end else begin
            if (efg && !kill) begin
                r.due = cyc + 1; r.is_fe = 1'b1; r.data = exp_mem[fa[9:2]];
                sb.push_back(r);
            end
            if (elg && !we) begin
                r.due = cyc + 1; r.is_fe = 1'b0; r.data = exp_mem[la[9:2]];
                sb.push_back(r);
            end
            if (elg && we) exp_mem[la[9:2]] = wd;
            if (fr && !efg) exp_stall++;
            if (elg) exp_ldg++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkPerf();

        // Back-to-back fetches of 0x0, 0x4, 0x8.
        applyStimulus(1, 1, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 32'h4, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 32'h8, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Starvation: loader refused 8 times, wins the 9th and opens a locked write burst.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1, 32'hC + 32'(4 * i), 0, 1, 1, 32'h100, 32'hA0, 1, 1, 0);
        end
        applyStimulus(1, 1, 32'h30, 0, 1, 1, 32'h100, 32'hA0, 1, 0, 1);
        applyStimulus(1, 1, 32'h30, 0, 1, 1, 32'h104, 32'hA1, 1, 0, 1);
        applyStimulus(1, 1, 32'h30, 0, 1, 1, 32'h108, 32'hA2, 1, 0, 1);
        applyStimulus(1, 1, 32'h30, 0, 1, 1, 32'h10C, 32'hA3, 0, 0, 1);
        applyStimulus(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Kill of a response in flight; loader response unaffected by kill.
        applyStimulus(1, 1, 32'h20, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'h0, 1, 1, 0, 32'h104, 0, 0, 0, 1);
        applyStimulus(1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0);
        // Kill in the grant cycle.
        applyStimulus(1, 1, 32'h0, 1, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a locked read burst.
        applyStimulus(1, 0, 32'h0, 0, 1, 0, 32'h108, 0, 1, 0, 1);
        applyStimulus(1, 1, 32'h0, 0, 1, 0, 32'h10C, 0, 1, 0, 1);
        applyStimulus(0, 1, 32'h0, 0, 1, 0, 32'h10C, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h4, 0, 1, 0, 32'h10C, 0, 0, 1, 0);

        // Perf scenario: 5 refused fetch cycles and 3 loader grants since reset.
        applyStimulus(1, 0, 32'h0, 0, 1, 1, 32'h200, 32'h55, 1, 0, 1);
        applyStimulus(1, 1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h8, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h8, 0, 1, 1, 32'h204, 32'h56, 1, 0, 1);
        applyStimulus(1, 1, 32'h8, 0, 1, 1, 32'h208, 32'h57, 0, 0, 1);
        checkPerf();
        applyStimulus(1, 1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkPerf();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction memory between two requesters.
  - Fetch requester (FE stage): read-only, normally highest priority.
  - Loader/debug requester: read or write, e.g. program load or debugger peek/poke.
- Performs per-cycle arbitration and starvation protection for the loader, and supports a locked loader burst.
- Returns read data with fixed 1-cycle latency, routed to the requester that owned the access.
- Sits between the FE stage PC/latch logic and the imem array; FE stalls when not granted.

Parameters:
- DBITS, 32, data/address width.
- IMEMADDRBITS, 16, byte-address bits covering imem.
- IMEMWORDBITS, 2, log2 of bytes per word; word index = addr[IMEMADDRBITS-1:IMEMWORDBITS].
- STARVE_MAX, 8, consecutive denied loader cycles before the loader is forced to win.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- fe_req  in  1  fetch read request.
- fe_addr  in  DBITS  fetch byte address.
- fe_kill  in  1  branch redirect; discard the fetch response in flight.
- fe_gnt  out  1  fetch request accepted this cycle (combinational).
- fe_rvalid  out  1  fetch read data valid.
- fe_rdata  out  DBITS  fetch read data.
- ld_req  in  1  loader request.
- ld_we  in  1  loader write (1) / read (0).
- ld_addr  in  DBITS  loader byte address.
- ld_wdata  in  DBITS  loader write data.
- ld_lock  in  1  keep the grant after this access (burst).
- ld_gnt  out  1  loader request accepted this cycle (combinational).
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  DBITS  loader read data.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write.
- mem_addr  out  IMEMADDRBITS-IMEMWORDBITS  word index.
- mem_wdata  out  DBITS  memory write data.
- mem_rdata  in  DBITS  memory read data, valid 1 cycle after a read.
- perf_fe_stall  out  32  FE cycles requested but not granted (see Optional Feature).
- perf_ld_grants  out  32  loader grants (see Optional Feature).

Behaviour:
- Reset (reset==0 at posedge clk):
  - FSM goes to ARB; starve counter = 0; owner_q = NONE.
  - fe_rvalid, ld_rvalid = 0; rdata outputs = 0; perf counters = 0.
  - Reset in mid-burst drops the lock and any in-flight response.
- FSM state ARB:
  - If starve_cnt == STARVE_MAX and ld_req: grant loader.
  - Else if fe_req: grant FE.
  - Else if ld_req: grant loader.
  - Exactly one grant per cycle at most.
  - Loader granted with ld_lock=1 -> LOCK.
- FSM state LOCK:
  - Loader is the only grantee; fe_gnt = 0.
  - Stays in LOCK while ld_lock=1.
  - Returns to ARB in the first cycle ld_lock=0, whether ld_req is high or not. An access accepted in that cycle is still granted to the loader.
- Memory drive:
  - mem_en = fe_gnt | ld_gnt; mem_we = ld_gnt & ld_we.
  - mem_addr comes from the granted requester's address with byte-offset bits ignored; mem_wdata = ld_wdata.
- Response path:
  - owner_q records the granted read requester (FE / LD / NONE); writes record NONE.
  - Next cycle: the owner's rvalid = 1 and its rdata = mem_rdata; the other requester's rvalid = 0.
  - rdata holds its last value when rvalid = 0.
- fe_kill:
  - If asserted in the cycle an FE response is due, fe_rvalid is forced to 0.
  - If asserted in the same cycle as fe_gnt, that new access is also killed, i.e. its response one cycle later is suppressed.
  - fe_kill never affects loader responses.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on each cycle with ld_req=1 and ld_gnt=0.
  - Clears on ld_gnt or when ld_req=0.
- Back-to-back: one access per cycle sustained; no bubble between grants of different owners.

Optional Feature:
- IMEM_ARB_PERF_EN defined:
  - perf_fe_stall increments on fe_req & !fe_gnt.
  - perf_ld_grants increments on ld_gnt.
  - Both 32-bit, wrapping, cleared by reset.
- Not defined: both outputs tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package/include: state encoding (ARB, LOCK), owner encoding (NONE, FE, LD), word-index slice macro, default STARVE_MAX.
- One natural sub-module: imem_arb_starve_cnt (saturating counter with inc/clr/sat_out).

Test Plan:
- fe_req every cycle, addrs 0x0,0x4,0x8; mem returns 0x11,0x22,0x33 -> fe_gnt=1 each cycle; fe_rvalid the cycle after each grant with rdata 0x11,0x22,0x33.
- fe_req and ld_req held high, STARVE_MAX=8 -> ld_gnt=0 for 8 cycles, then ld_gnt=1 on the 9th cycle with fe_gnt=0, counter back to 0.
- ld_req with ld_lock=1 for 4 writes to 0x100..0x10C, fe_req high throughout -> mem_we=1, mem_addr 0x40..0x43, fe_gnt=0 for 4 cycles; ld_lock=0 on the 4th access -> FE granted the next cycle.
- FE read of 0x20 granted, fe_kill=1 the next cycle -> fe_rvalid=0 that cycle; a loader read granted in the same cycle still returns ld_rvalid=1.
- reset=0 asserted mid-LOCK with a read in flight -> the next cycle shows ld_rvalid=0 and state ARB; with fe_req=1 after release, fe_gnt=1 immediately.
- IMEM_ARB_PERF_EN defined, 5 denied FE cycles and 3 loader grants -> perf_fe_stall=5, perf_ld_grants=3; macro undefined -> both read 0.
